div_sched: RTL and testbench
============================

DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter: NREQ, 4, number of requesters, 2..8.
REQ-002 Parameter: ITER, 2, convergence iterations per division, 1..4.
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: reset  in  1  synchronous active-low reset (low = reset), sampled on rising clk.
REQ-005 Port: req  in  NREQ  per-requester division request, held high until matching ack.
REQ-006 Port: n_in  in  9*NREQ  packed numerators; slice i = n_in[9i+8:9i], 8 fraction bits.
REQ-007 Port: d_in  in  9*NREQ  packed denominators; same packing and format.
REQ-008 Port: ack  out  NREQ  one-hot, one-cycle pulse, meaning the request was accepted and operands captured.
REQ-009 Port: q_out  out  9  quotient, 8 fraction bits.
REQ-010 Port: q_valid  out  1  one-cycle pulse, meaning q_out and q_id are valid.
REQ-011 Port: q_id  out  clog2(NREQ)  index of the requester owning q_out.
REQ-012 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states: IDLE, ITER, DONE; single shared divider datapath.
REQ-014 IDLE with any req high: grant the round-robin winner, capture x={0,n_i} and t={0,d_i} (10 bits, guard bit), clear the iteration counter, and go to ITER; ack[i] is high for the next cycle only.
REQ-015 Round-robin: search starts at (last granted + 1) mod NREQ; after reset, the last-granted pointer is NREQ-1, so requester 0 has first priority.
REQ-016 ITER, each cycle: f=512-t (10 bits); x<=(x*f)[17:8]; t<=(t*f)[17:8]; 20-bit products; counter increments; after the ITER-th update, go to DONE.
REQ-017 DONE: q_out<=x[8:0], q_id<=granted index, q_valid high for exactly one cycle, then IDLE.
REQ-018 Latency: q_valid is high in the cycle following edge (grant edge + ITER + 1); throughput is one division per ITER+2 cycles.
REQ-019 req is ignored outside IDLE; a req dropped before grant is never served; req still high in the ack cycle is not re-granted.
REQ-020 A request that is still high after its own DONE competes normally, and round-robin prevents starvation.
REQ-021 Denominator normalisation (d in 128..511) is the requester's responsibility; it is not checked except by REQ-024.
REQ-022 q_out and q_id hold their values between q_valid pulses.

Reset
REQ-023 reset low at a rising edge forces: state IDLE, ack 0, q_valid 0, q_out 0, q_id 0, busy 0, x/t/counter 0, pointer NREQ-1; an in-flight division is aborted and produces no q_valid.

Configuration
REQ-024 Macro DIV_SCHED_ZERO_CHK_EN defined: granted d=0 skips ITER and goes straight to DONE with q_out=511 (saturated); an extra output port div_err (1 bit) pulses together with q_valid. Undefined: no div_err port, and d=0 is iterated like any other value.

Structure
REQ-025 Shared package div_pkg holds the FSM state encoding, the constant TWO=512, and the 9/10/20-bit width constants.
REQ-026 Sub-module div_conv_step: a combinational single iteration (x,t -> x',t'), instantiated once.

Verification
REQ-027 Single request: req[0], n=128, d=192, ITER=2 -> ack[0] one cycle; q_valid 4 cycles after grant edge; q_out=170, q_id=0.
REQ-028 All four req high simultaneously, held -> grants in order 0,1,2,3,0; one q_valid per 4 cycles with matching q_id.
REQ-029 reset low during ITER -> no q_valid; busy=0 next cycle; the next grant goes to requester 0.
REQ-030 req[2] raised during busy, then req[1] raised in DONE cycle -> in IDLE, grant follows the round-robin pointer, not arrival order.
REQ-031 With DIV_SCHED_ZERO_CHK_EN, d=0 -> q_out=511 and div_err=1 two cycles after grant; without it, there is no div_err port.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and types for the time-shared Newton-Raphson divider.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, the fixed-point constant TWO (2.0 in Q.8 with
// a guard bit), the 9/10/20-bit widths and a Q.8 multiply helper.
package div_pkg;

    localparam int W9   = 9;    // operand / result width, 8 fraction bits
    localparam int W10  = 10;   // internal width: operand plus guard bit
    localparam int W20  = 20;   // full product width of two W10 values
    localparam int FRAC = 8;    // fraction bits

    // 2.0 in the internal Q.8 format.
    localparam logic [W10-1:0] TWO = 10'd512;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Q.8 multiply: full 20-bit product, renormalised by dropping the low
    // FRAC bits and keeping the next W10 bits (product bits [17:8]).
    function automatic logic [W10-1:0] fix_mul(input logic [W10-1:0] a,
                                               input logic [W10-1:0] b);
        logic [W20-1:0] p;
        p = {{(W20-W10){1'b0}}, a} * {{(W20-W10){1'b0}}, b};
        return p[FRAC+W10-1:FRAC];
    endfunction

endpackage

// File: rtl/div_conv_step.sv
// One Goldschmidt convergence step: x' = x*(2-t), t' = t*(2-t), Q.8 fixed point.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   x, t         in   10  current numerator / denominator estimates (guard bit + Q.8)
//   x_nxt, t_nxt out  10  estimates after one step
module div_conv_step
    import div_pkg::*;
(
    input  logic [W10-1:0] x,
    input  logic [W10-1:0] t,
    output logic [W10-1:0] x_nxt,
    output logic [W10-1:0] t_nxt
);

    logic [W10-1:0] f;

    // Correction factor; wraps modulo 1024 if t ever exceeds 2.0, which only
    // happens for un-normalised denominators.
    assign f     = TWO - t;
    assign x_nxt = fix_mul(x, f);
    assign t_nxt = fix_mul(t, f);

endmodule

// File: rtl/div_sched.sv
// Round-robin scheduler in front of one shared iterative Q.8 divider.
// Latency: q_valid in the cycle after edge (grant edge + ITER + 1); one division per ITER+2 cycles.
// Backpressure: requesters hold req until their one-cycle ack; req is ignored while busy.
//
// Ports:
//   clk      in   1             clock, all state on rising edge
//   reset    in   1             synchronous active-low reset
//   req      in   NREQ          per-requester request, held until ack
//   n_in     in   9*NREQ        packed numerators, slice i = n_in[9i+8:9i]
//   d_in     in   9*NREQ        packed denominators, same packing
//   ack      out  NREQ          one-hot pulse: request accepted, operands captured
//   q_out    out  9             quotient, held between q_valid pulses
//   q_valid  out  1             one-cycle pulse, q_out / q_id valid
//   q_id     out  clog2(NREQ)   requester owning q_out
//   busy     out  1             high whenever the FSM is not idle
//   div_err  out  1             (DIV_SCHED_ZERO_CHK_EN only) pulses with q_valid on d=0
//
// Build option: DIV_SCHED_ZERO_CHK_EN -- a granted zero denominator bypasses
// the iterations and returns the saturated quotient 511 with div_err.
module div_sched
    import div_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ITER = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NREQ-1:0]                         req,
    input  logic [W9*NREQ-1:0]                      n_in,
    input  logic [W9*NREQ-1:0]                      d_in,
    output logic [NREQ-1:0]                         ack,
    output logic [W9-1:0]                           q_out,
    output logic                                    q_valid,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] q_id,
    output logic                                    busy
`ifdef DIV_SCHED_ZERO_CHK_EN
    ,
    output logic                                    div_err
`endif
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t         state;
    state_t         state_nxt;
    logic           start;

    // Last granted requester; doubles as the owner of the division in flight.
    logic [IW-1:0]  last_gnt;
    logic [IW-1:0]  gnt_idx;
    logic           gnt_any;

    logic [W9-1:0]  n_sel;
    logic [W9-1:0]  d_sel;
    logic           d_zero;

    logic [W10-1:0] x;
    logic [W10-1:0] t;
    logic [W10-1:0] x_nxt;
    logic [W10-1:0] t_nxt;
    logic [2:0]     cnt;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan upward from the requester after last_gnt,
    // wrapping, so the previous winner has the lowest priority next time.
    // ------------------------------------------------------------------
    always_comb begin : arb
        int idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last_gnt) + k) % NREQ;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
    end

    assign n_sel = n_in[int'(gnt_idx)*W9 +: W9];
    assign d_sel = d_in[int'(gnt_idx)*W9 +: W9];

`ifdef DIV_SCHED_ZERO_CHK_EN
    assign d_zero = (d_sel == '0);
`else
    assign d_zero = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    start     = 1'b1;
                    state_nxt = d_zero ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                // cnt counts completed updates; this cycle performs update cnt+1.
                if (cnt == 3'(ITER - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Shared datapath
    // ------------------------------------------------------------------
    div_conv_step u_step (
        .x     (x),
        .t     (t),
        .x_nxt (x_nxt),
        .t_nxt (t_nxt)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            x        <= '0;
            t        <= '0;
            cnt      <= '0;
            last_gnt <= IW'(NREQ - 1);
            ack      <= '0;
            q_valid  <= 1'b0;
            q_out    <= '0;
            q_id     <= '0;
        end else begin
            ack     <= '0;
            q_valid <= 1'b0;

            if (start) begin
                // A zero denominator (only flagged when the check is built in)
                // loads the saturated quotient so DONE needs no special case.
                x        <= d_zero ? 10'd511 : {1'b0, n_sel};
                t        <= {1'b0, d_sel};
                cnt      <= '0;
                last_gnt <= gnt_idx;
                ack      <= NREQ'(1) << gnt_idx;
            end

            if (state == S_ITER) begin
                x   <= x_nxt;
                t   <= t_nxt;
                cnt <= cnt + 3'd1;
            end

            if (state == S_DONE) begin
                q_valid <= 1'b1;
                q_out   <= x[W9-1:0];
                q_id    <= last_gnt;
            end
        end
    end

`ifdef DIV_SCHED_ZERO_CHK_EN
    logic zflag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            zflag   <= 1'b0;
            div_err <= 1'b0;
        end else begin
            div_err <= 1'b0;
            if (start) begin
                zflag <= d_zero;
            end
            if (state == S_DONE) begin
                div_err <= zflag;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched (NREQ=4, ITER=2).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_div_sched;

    localparam int NREQ = 4;
    localparam int ITER = 2;
    localparam int LAT  = ITER + 1;   // ack observation to q_valid observation

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [9*NREQ-1:0]    n_in = '0;
    logic [9*NREQ-1:0]    d_in = '0;
    logic [NREQ-1:0]      ack;
    logic [8:0]           q_out;
    logic                 q_valid;
    logic [1:0]           q_id;
    logic                 busy;
`ifdef DIV_SCHED_ZERO_CHK_EN
    logic                 div_err;
`endif

    div_sched #(.NREQ(NREQ), .ITER(ITER)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .n_in    (n_in),
        .d_in    (d_in),
        .ack     (ack),
        .q_out   (q_out),
        .q_valid (q_valid),
        .q_id    (q_id),
        .busy    (busy)
`ifdef DIV_SCHED_ZERO_CHK_EN
        ,
        .div_err (div_err)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] mask;   // requesters raised together
        int         n;      // numerator for the expected winner
        int         d;      // denominator for the expected winner
        int         id;     // expected winner
        int         q;      // expected quotient
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner slice gets the operands; every other slice divides 0 by 1.0.
    task automatic load(input int id, input int n, input int d);
        for (int i = 0; i < NREQ; i++) begin
            n_in[9*i +: 9] = 9'd0;
            d_in[9*i +: 9] = 9'd256;
        end
        n_in[9*id +: 9] = 9'(n);
        d_in[9*id +: 9] = 9'(d);
    endtask

    task automatic wait_ack(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (ack == '0 && cyc < 16);
    endtask

    task automatic wait_qv(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!q_valid && cyc < 16);
    endtask

    initial begin
        int c;
        int prev_q;
        int qv_seen;

        vecs[0] = '{4'b0001, 128, 192, 0, 170};
        vecs[1] = '{4'b1101, 256, 256, 2, 256};
        vecs[2] = '{4'b0011,  64, 128, 0, 120};
        vecs[3] = '{4'b1010, 200, 400, 1, 114};
        vecs[4] = '{4'b1000, 511, 511, 3,   1};
        vecs[5] = '{4'b0110,   0, 300, 1,   0};
        vecs[6] = '{4'b0101, 300, 128, 2,  50};
`ifdef DIV_SCHED_ZERO_CHK_EN
        vecs[7] = '{4'b1111, 128, 256, 3, 128};
`else
        vecs[7] = '{4'b1111, 128,   0, 3,   0};
`endif

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_ack",     int'(ack),     0);
        chk("rst_q_valid", int'(q_valid), 0);
        chk("rst_q_out",   int'(q_out),   0);
        chk("rst_q_id",    int'(q_id),    0);
        chk("rst_busy",    int'(busy),    0);
        reset = 1'b1;
        tick();

        // ---------------- table: arbitration + arithmetic ----------------
        prev_q = 0;
        for (int v = 0; v < 8; v++) begin
            load(vecs[v].id, vecs[v].n, vecs[v].d);
            req = vecs[v].mask;
            wait_ack(c);
            chk($sformatf("v%0d_grant_lat", v), c, 1);
            chk($sformatf("v%0d_ack", v), int'(ack), 1 << vecs[v].id);
            chk($sformatf("v%0d_qv_low", v), int'(q_valid), 0);
            chk($sformatf("v%0d_q_hold", v), int'(q_out), prev_q);
            req = '0;
            tick();
            chk($sformatf("v%0d_ack_pulse", v), int'(ack), 0);
            chk($sformatf("v%0d_busy", v), int'(busy), 1);
            wait_qv(c);
            chk($sformatf("v%0d_lat", v), c, LAT - 1);
            chk($sformatf("v%0d_q_out", v), int'(q_out), vecs[v].q);
            chk($sformatf("v%0d_q_id", v), int'(q_id), vecs[v].id);
            chk($sformatf("v%0d_idle", v), int'(busy), 0);
            prev_q = vecs[v].q;
        end

        // ---------------- all four held: 0,1,2,3,0 ----------------
        for (int i = 0; i < NREQ; i++) begin
            n_in[9*i +: 9] = 9'd128;
            d_in[9*i +: 9] = 9'd192;
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ack(c);
            chk($sformatf("rr%0d_grant_lat", k), c, 1);
            chk($sformatf("rr%0d_ack", k), int'(ack), 1 << (k % 4));
            if (k == 4) req = '0;
            wait_qv(c);
            chk($sformatf("rr%0d_lat", k), c, LAT);
            chk($sformatf("rr%0d_q_id", k), int'(q_id), k % 4);
            chk($sformatf("rr%0d_q_out", k), int'(q_out), 170);
        end

        // ---------------- reset during ITER ----------------
        load(2, 128, 192);
        req = 4'b0100;
        wait_ack(c);
        chk("abort_ack", int'(ack), 4'b0100);
        req = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("abort_busy",    int'(busy),    0);
        chk("abort_ack_clr", int'(ack),     0);
        chk("abort_q_out",   int'(q_out),   0);
        chk("abort_q_id",    int'(q_id),    0);
        reset = 1'b1;
        qv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (q_valid) qv_seen++;
        end
        chk("abort_no_qv", qv_seen, 0);
        load(0, 64, 128);
        req = 4'b1001;
        wait_ack(c);
        chk("post_rst_ack", int'(ack), 4'b0001);
        req = '0;
        wait_qv(c);
        chk("post_rst_q_out", int'(q_out), 120);
        chk("post_rst_q_id",  int'(q_id),  0);

        // ---------------- late arrivals follow the pointer ----------------
        load(3, 200, 400);
        n_in[9 +: 9] = 9'd256;
        d_in[9 +: 9] = 9'd256;
        req = 4'b1000;
        wait_ack(c);
        chk("late_ack3", int'(ack), 4'b1000);
        req = '0;
        tick();
        req[2] = 1'b1;               // arrives during ITER
        tick();
        chk("late_busy_ignored", int'(ack), 0);
        req[1] = 1'b1;               // arrives in DONE
        tick();
        chk("late_qv",     int'(q_valid), 1);
        chk("late_q_id",   int'(q_id),    3);
        chk("late_q_out",  int'(q_out),   114);
        chk("late_no_ack", int'(ack),     0);
        tick();
        chk("late_rr_ack", int'(ack), 4'b0010);
        req = '0;
        wait_qv(c);
        chk("late_rr_q_id",  int'(q_id),  1);
        chk("late_rr_q_out", int'(q_out), 256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
